// File: rtl/seq_window_checker.sv
// rtl/seq_window_checker.sv - START/STOP window checker on a nibble stream
// with pass/fail pulses, fail cause, last latency and saturating counters.
module seq_window_checker #(
    parameter logic [3:0] START   = 4'h1,
    parameter logic [3:0] STOP    = 4'h2,
    parameter int         MIN_DLY = 1,
    parameter int         MAX_DLY = 4,
    parameter int         CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       din,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_cause,
    output logic [7:0]       last_lat,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0]       MIN_C   = 8'(MIN_DLY);
    localparam logic [7:0]       MAX_C   = 8'(MAX_DLY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       pass_nx, fail_nx;
    logic [1:0] cause_nx;
    logic [7:0] lat_nx;
    logic       din_unknown;

    // Always false in synthesis, so an X/Z nibble simply falls through there.
    assign din_unknown = ((^din) === 1'bx);
    assign busy        = (state == WAIT);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pass_nx  = 1'b0;
        fail_nx  = 1'b0;
        cause_nx = fail_cause;
        lat_nx   = last_lat;
        case (state)
            IDLE: begin
                if (din === START) begin
                    state_nx = WAIT;
                    cnt_nx   = 8'd1;
                end
            end
            WAIT: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
                if (din_unknown) begin
                    fail_nx  = 1'b1;
                    cause_nx = 2'd3;
                end else if ((din === STOP) && (cnt < MIN_C)) begin
                    fail_nx  = 1'b1;
                    cause_nx = 2'd1;
                end else if (din === STOP) begin
                    pass_nx = 1'b1;
                    lat_nx  = cnt;
                end else if (cnt == MAX_C) begin
                    fail_nx  = 1'b1;
                    cause_nx = 2'd2;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = cnt + 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_cause <= 2'd0;
            last_lat   <= 8'd0;
            pass_count <= '0;
            fail_count <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            pass       <= pass_nx;
            fail       <= fail_nx;
            fail_cause <= cause_nx;
            last_lat   <= lat_nx;
            if (pass_nx && (pass_count != CNT_MAX))
                pass_count <= pass_count + CNT_W'(1);
            if (fail_nx && (fail_count != CNT_MAX))
                fail_count <= fail_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_window_checker.sv
// tb/tb_seq_window_checker.sv - randomized and directed bench for seq_window_checker
// against a timestamp-based window model, on two parameterisations.
module tb_seq_window_checker;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] din   = 4'h0;

    logic       busy_a, pass_a, fail_a, busy_b, pass_b, fail_b;
    logic [1:0] cause_a, cause_b;
    logic [7:0] lat_a, lat_b;
    logic [7:0] pc_a, fc_a;
    logic [1:0] pc_b, fc_b;

    seq_window_checker #(.START(4'h1), .STOP(4'h2), .MIN_DLY(1), .MAX_DLY(4), .CNT_W(8)) dut_a (
        .clock(clock), .reset(reset), .din(din), .busy(busy_a), .pass(pass_a), .fail(fail_a),
        .fail_cause(cause_a), .last_lat(lat_a), .pass_count(pc_a), .fail_count(fc_a));

    seq_window_checker #(.START(4'h1), .STOP(4'h2), .MIN_DLY(2), .MAX_DLY(5), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .din(din), .busy(busy_b), .pass(pass_b), .fail(fail_b),
        .fail_cause(cause_b), .last_lat(lat_b), .pass_count(pc_b), .fail_count(fc_b));

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: a window is an open flag plus the cycle its START was sampled.
    int min_d[2] = '{1, 2};
    int max_d[2] = '{4, 5};
    int cmax[2]  = '{255, 3};
    bit m_open[2];
    int m_start[2];
    int e_busy[2], e_pass[2], e_fail[2], e_cause[2], e_lat[2], e_pc[2], e_fc[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        int el;
        if (reset) begin
            m_open[i] = 0;
            e_busy[i] = 0; e_pass[i] = 0; e_fail[i] = 0;
            e_cause[i] = 0; e_lat[i] = 0; e_pc[i] = 0; e_fc[i] = 0;
        end else begin
            e_pass[i] = 0;
            e_fail[i] = 0;
            if (m_open[i]) begin
                el = cyc - m_start[i];
                if ($isunknown(din)) begin
                    e_fail[i] = 1; e_cause[i] = 3;
                end else if (din === 4'h2 && el < min_d[i]) begin
                    e_fail[i] = 1; e_cause[i] = 1;
                end else if (din === 4'h2) begin
                    e_pass[i] = 1; e_lat[i] = el;
                end else if (el >= max_d[i]) begin
                    e_fail[i] = 1; e_cause[i] = 2;
                end
                if (e_pass[i] || e_fail[i]) m_open[i] = 0;
            end else if (din === 4'h1) begin
                m_open[i]  = 1;
                m_start[i] = cyc;
            end
            if (e_pass[i] && e_pc[i] < cmax[i]) e_pc[i]++;
            if (e_fail[i] && e_fc[i] < cmax[i]) e_fc[i]++;
            e_busy[i] = m_open[i];
        end
    endtask

    always @(posedge clock) begin
        cyc++;
        model_step(0);
        model_step(1);
        #1;
        chk("busy_a", busy_a, e_busy[0]);   chk("busy_b", busy_b, e_busy[1]);
        chk("pass_a", pass_a, e_pass[0]);   chk("pass_b", pass_b, e_pass[1]);
        chk("fail_a", fail_a, e_fail[0]);   chk("fail_b", fail_b, e_fail[1]);
        chk("cause_a", cause_a, e_cause[0]); chk("cause_b", cause_b, e_cause[1]);
        chk("lat_a", lat_a, e_lat[0]);      chk("lat_b", lat_b, e_lat[1]);
        chk("pcnt_a", pc_a, e_pc[0]);       chk("pcnt_b", pc_b, e_pc[1]);
        chk("fcnt_a", fc_a, e_fc[0]);       chk("fcnt_b", fc_b, e_fc[1]);
    end

    task automatic step(input logic [3:0] v);
        @(negedge clock) din = v;
        @(posedge clock);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {busy_a, busy_b}, 0);
        chk({tag, "_pulse"}, {pass_a, fail_a, pass_b, fail_b}, 0);
        chk({tag, "_cause"}, {cause_a, cause_b}, 0);
        chk({tag, "_lat"}, {lat_a, lat_b}, 0);
        chk({tag, "_cnt"}, {pc_a, fc_a, pc_b, fc_b}, 0);
    endtask

    initial begin
        logic       xp;
        bit         x_sup;
        logic [3:0] v;
        int         r;
        xp    = 1'bx;
        x_sup = $isunknown(xp);

        step(4'h1);
        step(4'h2);
        chk_all_zero("rst");
        @(negedge clock) reset = 1'b0;

        // "0120": delay-1 window; too early for MIN_DLY=2.
        step(4'h0);
        step(4'h1);
        chk("t1_busy_a", busy_a, 1);
        step(4'h2);
        chk("t1_pass_a", pass_a, 1);  chk("t1_lat_a", lat_a, 1);
        chk("t1_pc_a", pc_a, 1);      chk("t1_busy_a_off", busy_a, 0);
        chk("t1_fail_b", fail_b, 1);  chk("t1_cause_b", cause_b, 1);
        chk("t1_fc_b", fc_b, 1);      chk("t1_busy_b_off", busy_b, 0);
        step(4'h0);

        // START with no STOP: timeout after MAX_DLY samples.
        step(4'h1);
        for (int k = 1; k <= 4; k++) begin
            step(4'h0);
            if (k < 4) chk("t2_busy_a", busy_a, 1);
        end
        chk("t2_fail_a", fail_a, 1);  chk("t2_cause_a", cause_a, 2);
        chk("t2_busy_a_off", busy_a, 0); chk("t2_busy_b", busy_b, 1);
        step(4'h0);
        chk("t2_fail_b", fail_b, 1);  chk("t2_cause_b", cause_b, 2);

        // "11120": repeated START ignored, latency from the first one.
        step(4'h1); step(4'h1); step(4'h1); step(4'h2);
        chk("t3_pass_a", pass_a, 1);  chk("t3_lat_a", lat_a, 3);
        chk("t3_pc_a", pc_a, 2);      chk("t3_fc_a", fc_a, 1);
        chk("t3_pass_b", pass_b, 1);  chk("t3_lat_b", lat_b, 3);

        // "1x" then a clean "12" window.
        step(4'h1);
        step(4'bxxxx);
        if (x_sup) begin
            chk("t4_fail_a", fail_a, 1);
            chk("t4_cause_a", cause_a, 3);
        end
        repeat (6) step(4'h0);
        step(4'h1); step(4'h2);
        chk("t4_pass_a", pass_a, 1);  chk("t4_lat_a", lat_a, 1);

        // Five passing windows on the 2-bit counter: saturates, never wraps.
        repeat (5) begin
            step(4'h1); step(4'h0); step(4'h2);
        end
        chk("t5_pc_b_sat", pc_b, 3);

        // Reset mid-window discards it and clears everything immediately.
        step(4'h1);
        @(negedge clock) reset = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        step(4'h2);
        chk_all_zero("mid_rst_hold");
        @(negedge clock) reset = 1'b0;
        step(4'h1); step(4'h2);
        chk("t6_pc_a", pc_a, 1);

        // Randomized phase, alternating STOP-rich and STOP-poor stretches.
        for (int it = 0; it < 3000; it++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                @(negedge clock) reset = 1'b1;
                @(negedge clock) reset = 1'b0;
            end else begin
                r = $urandom_range(0, 19);
                if ((it / 300) % 2 == 0)
                    v = (r < 7) ? 4'h1 : (r < 13) ? 4'h2 : (r < 18) ? 4'h0 : 4'($urandom);
                else
                    v = (r < 3) ? 4'h1 : (r < 4) ? 4'h2 : (r < 18) ? 4'h0 : 4'($urandom);
                step(v);
            end
        end

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
